// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - writeback bundle, decode read ports and retire state of the register file
//
// Carries the MEM/WB writeback slot (wb_reg_write, wb_dest, wb_data, wb_pc),
// the two decode read ports (rs1/rs2 address in, data out) and the
// architectural retire state (retire_cnt, last_pc, retire_pulse).
// master: pipeline side (drives writeback slot and read addresses)
// slave : register file side (drives read data and retire state)
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 32
);
  logic              wb_reg_write;
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic [31:0]       wb_pc;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [CNT_W-1:0]  retire_cnt;
  logic [31:0]       last_pc;
  logic              retire_pulse;

  modport master (
    output wb_reg_write, wb_dest, wb_data, wb_pc, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, retire_cnt, last_pc, retire_pulse
  );

  modport slave (
    input  wb_reg_write, wb_dest, wb_data, wb_pc, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, retire_cnt, last_pc, retire_pulse
  );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback-stage 16-entry register file with bypassed reads and retire tracking
//
// Ports:
//   clk   - single clock, all state updates on the rising edge
//   reset - asynchronous active-low reset
//   bus   - wb_regfile_if.slave: writeback slot in, two combinational
//           read ports out, retire counter / last retired PC / retire pulse out
module wb_regfile #(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 4,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] BUBBLE_PC = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         reset,
  wb_regfile_if.slave  bus
);

  localparam int NREG = 1 << ADDR_W;

  // Entry 0 is never written, so it stays at its reset value of zero; reads
  // of index 0 are forced to zero anyway so that a bypassed R0 write is hidden.
  logic [DATA_W-1:0] regs [NREG];

  logic              wr_en;
  logic              retire;
  logic [CNT_W-1:0]  retire_cnt_q;
  logic [31:0]       last_pc_q;
  logic              retire_pulse_q;

  assign wr_en  = bus.wb_reg_write && (bus.wb_dest != '0);
  // Enable is deliberately not gated by the bubble marker: the pipeline owns
  // clearing wb_reg_write on bubbles.
  assign retire = (bus.wb_pc != BUBBLE_PC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[bus.wb_dest] <= bus.wb_data;
    end
  end

  // Retire state counts every non-bubble slot, stores and branches included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_cnt_q   <= '0;
      last_pc_q      <= BUBBLE_PC;
      retire_pulse_q <= 1'b0;
    end else begin
      retire_pulse_q <= retire;
      if (retire) begin
        retire_cnt_q <= retire_cnt_q + 1'b1;
        last_pc_q    <= bus.wb_pc;
      end
    end
  end

  // Read ports: zero for R0, then same-cycle bypass of the presented write,
  // otherwise the array.
  always_comb begin
    bus.rs1_data = '0;
    if (bus.rs1_addr != '0) begin
      if (bus.wb_reg_write && (bus.wb_dest == bus.rs1_addr)) begin
        bus.rs1_data = bus.wb_data;
      end else begin
        bus.rs1_data = regs[bus.rs1_addr];
      end
    end
  end

  always_comb begin
    bus.rs2_data = '0;
    if (bus.rs2_addr != '0) begin
      if (bus.wb_reg_write && (bus.wb_dest == bus.rs2_addr)) begin
        bus.rs2_data = bus.wb_data;
      end else begin
        bus.rs2_data = regs[bus.rs2_addr];
      end
    end
  end

  assign bus.retire_cnt   = retire_cnt_q;
  assign bus.last_pc      = last_pc_q;
  assign bus.retire_pulse = retire_pulse_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed self-checking bench for wb_regfile
module tb_wb_regfile;

  localparam logic [31:0] BUB = 32'hFFFF_FFFF;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  wb_regfile_if #(.DATA_W(32), .ADDR_W(4), .CNT_W(32)) bus ();
  wb_regfile_if #(.DATA_W(32), .ADDR_W(4), .CNT_W(4))  bus4 ();

  wb_regfile #(.DATA_W(32), .ADDR_W(4), .CNT_W(32), .BUBBLE_PC(BUB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Narrow-counter instance sees exactly the same slot stream.
  wb_regfile #(.DATA_W(32), .ADDR_W(4), .CNT_W(4), .BUBBLE_PC(BUB)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  assign bus4.wb_reg_write = bus.wb_reg_write;
  assign bus4.wb_dest      = bus.wb_dest;
  assign bus4.wb_data      = bus.wb_data;
  assign bus4.wb_pc        = bus.wb_pc;
  assign bus4.rs1_addr     = bus.rs1_addr;
  assign bus4.rs2_addr     = bus.rs2_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic slot(input logic we, input logic [3:0] dest, input logic [31:0] data,
                      input logic [31:0] pc);
    bus.wb_reg_write = we;
    bus.wb_dest      = dest;
    bus.wb_data      = data;
    bus.wb_pc        = pc;
  endtask

  // Advance past the next rising edge; leaves time 1 unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    slot(1'b0, 4'd0, 32'h0, BUB);
    bus.rs1_addr = 4'd3;
    bus.rs2_addr = 4'd5;

    // Reset state
    #12;
    check("rst_rs1", bus.rs1_data, 32'h0);
    check("rst_rs2", bus.rs2_data, 32'h0);
    check("rst_cnt", bus.retire_cnt, 32'h0);
    check("rst_last_pc", bus.last_pc, 32'hFFFF_FFFF);
    check("rst_pulse", bus.retire_pulse, 1'b0);
    reset = 1'b1;

    // Write R3 and read it back through the array
    slot(1'b1, 4'd3, 32'h0000_1234, 32'h10);
    tick();
    slot(1'b0, 4'd0, 32'h0, BUB);
    #1;
    check("wr_rs1_r3", bus.rs1_data, 32'h0000_1234);
    check("wr_cnt", bus.retire_cnt, 32'd1);
    check("wr_last_pc", bus.last_pc, 32'h10);
    check("wr_pulse_hi", bus.retire_pulse, 1'b1);
    tick();
    check("wr_pulse_lo", bus.retire_pulse, 1'b0);
    check("wr_cnt_hold", bus.retire_cnt, 32'd1);

    // Bypass: R5 preloaded, then overwritten with both ports on R5
    slot(1'b1, 4'd5, 32'hAAAA_0000, BUB);
    tick();
    bus.rs1_addr = 4'd5;
    slot(1'b0, 4'd0, 32'h0, BUB);
    #1;
    check("byp_pre_r5", bus.rs1_data, 32'hAAAA_0000);
    slot(1'b1, 4'd5, 32'h0BAD_F00D, BUB);
    #1;
    check("byp_rs1", bus.rs1_data, 32'h0BAD_F00D);
    check("byp_rs2", bus.rs2_data, 32'h0BAD_F00D);
    tick();
    slot(1'b0, 4'd0, 32'h0, BUB);
    #1;
    check("byp_arr_rs1", bus.rs1_data, 32'h0BAD_F00D);
    check("byp_arr_rs2", bus.rs2_data, 32'h0BAD_F00D);
    check("byp_cnt_bubble", bus.retire_cnt, 32'd1);
    check("byp_pulse_bubble", bus.retire_pulse, 1'b0);

    // R0 write is discarded but the slot still retires
    bus.rs1_addr = 4'd0;
    slot(1'b1, 4'd0, 32'hFFFF_FFFF, 32'h30);
    #1;
    check("r0_same_cycle", bus.rs1_data, 32'h0);
    tick();
    slot(1'b0, 4'd0, 32'h0, BUB);
    #1;
    check("r0_after_edge", bus.rs1_data, 32'h0);
    check("r0_cnt", bus.retire_cnt, 32'd2);
    check("r0_last_pc", bus.last_pc, 32'h30);
    check("r0_pulse", bus.retire_pulse, 1'b1);

    // Alternating valid/bubble slots
    for (int i = 0; i < 6; i++) begin
      slot(1'b0, 4'd0, 32'h0, (i % 2 == 0) ? 32'h20 : BUB);
      tick();
      check($sformatf("bub_pulse_%0d", i), bus.retire_pulse, (i % 2 == 0) ? 1'b1 : 1'b0);
    end
    slot(1'b0, 4'd0, 32'h0, BUB);
    check("bub_cnt", bus.retire_cnt, 32'd5);
    check("bub_last_pc", bus.last_pc, 32'h20);

    // Asynchronous reset between edges clears R3 immediately
    bus.rs1_addr = 4'd3;
    #1;
    check("pre_async_r3", bus.rs1_data, 32'h0000_1234);
    reset = 1'b0;
    #1;
    check("async_r3", bus.rs1_data, 32'h0);
    check("async_cnt", bus.retire_cnt, 32'h0);
    check("async_last_pc", bus.last_pc, 32'hFFFF_FFFF);
    // Bypass still visible while held in reset
    bus.rs1_addr = 4'd7;
    slot(1'b1, 4'd7, 32'h0000_0077, 32'h50);
    #1;
    check("rst_bypass_r7", bus.rs1_data, 32'h0000_0077);
    tick();
    reset = 1'b1;

    // Reset asserted during the cycle of an R7 write: write and retire lost
    #1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    slot(1'b0, 4'd0, 32'h0, BUB);
    #1;
    check("lost_r7", bus.rs1_data, 32'h0);
    check("lost_cnt", bus.retire_cnt, 32'h0);
    check("lost_last_pc", bus.last_pc, 32'hFFFF_FFFF);

    // 17 retiring slots: 4-bit counter wraps to 0 after 16, ends at 1
    for (int i = 0; i < 17; i++) begin
      slot(1'b0, 4'd0, 32'h0, 32'h100 + 32'(4 * i));
      tick();
      if (i == 15) check("wrap_cnt4_16", bus4.retire_cnt, 4'd0);
    end
    slot(1'b0, 4'd0, 32'h0, BUB);
    check("wrap_cnt4_17", bus4.retire_cnt, 4'd1);
    check("wrap_cnt32_17", bus.retire_cnt, 32'd17);
    check("wrap_last_pc", bus.last_pc, 32'h140);
    tick();
    check("wrap_pulse_end", bus4.retire_pulse, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-stage register file that sits at the consuming end of the MEM/WB pipeline register. It accepts the registered writeback bundle (write enable, destination, data, PC) and commits it to a 16-entry general-purpose register file. It serves two combinational read ports to decode, with same-cycle write-to-read bypass. It also keeps architectural retire state: a retired-instruction counter and the PC of the last retired instruction.

## Interface
Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 4, register index width (2^ADDR_W = 16 registers)
- CNT_W, 32, retire counter width
- BUBBLE_PC, 32'hFFFFFFFF, PC value that marks a bubble/no-instruction slot

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset; asserted when 0
- wb_reg_write  in  1  commit wb_data to wb_dest this cycle
- wb_dest  in  ADDR_W  destination register index
- wb_data  in  DATA_W  writeback data
- wb_pc  in  32  PC of the instruction in writeback; BUBBLE_PC = empty slot
- rs1_addr  in  ADDR_W  read port 1 index
- rs2_addr  in  ADDR_W  read port 2 index
- rs1_data  out  DATA_W  read port 1 data (combinational)
- rs2_data  out  DATA_W  read port 2 data (combinational)
- retire_cnt  out  CNT_W  count of retired (non-bubble) instructions
- last_pc  out  32  PC of most recently retired instruction
- retire_pulse  out  1  registered; high for one cycle after each retire

## Operation
- Register array R0..R15, DATA_W each. R0 is hardwired zero: writes to R0 are discarded and reads of R0 return 0.
- Write: at the rising edge with reset high, if wb_reg_write=1 and wb_dest!=0, then R[wb_dest] <= wb_data.
- Read: rsN_data = 0 if rsN_addr=0.
  - Otherwise, if wb_reg_write=1 and wb_dest=rsN_addr, rsN_data = wb_data (bypass).
  - Otherwise rsN_data = R[rsN_addr].
  - Both ports are independent and may address the same register.
- Retire: the slot retires when wb_pc != BUBBLE_PC, regardless of wb_reg_write, so stores and branches count.
  - On retire at the edge: retire_cnt <= retire_cnt+1 (modulo 2^CNT_W, wraps to 0), last_pc <= wb_pc, retire_pulse <= 1.
  - On a bubble: retire_cnt and last_pc hold, and retire_pulse <= 0.
- A bubble slot with wb_reg_write=1 still performs the register write. The pipeline is responsible for clearing the enable on bubbles; the block does not mask it.
- Reset (reset=0, asynchronous, immediate, independent of clk):
  - All R[i] = 0.
  - retire_cnt = 0, last_pc = BUBBLE_PC, retire_pulse = 0.
  - rs1_data/rs2_data remain combinational and reflect the cleared array, plus the bypass if inputs drive it.
- Reset asserted mid-operation: any write or retire pending for that edge is lost. No partial updates.
- Reset deassertion: the first state update occurs at the first rising clk edge with reset=1.

## Timing
- Write latency: a value is visible through the array one cycle after the write edge, and visible the same cycle through the bypass.
- Read latency: zero cycles (combinational), from rsN_addr, wb_reg_write, wb_dest and wb_data.
- retire_cnt, last_pc and retire_pulse change only at the rising edge (or on async reset). retire_pulse asserts in the cycle after the retiring slot is presented.
- Back-to-back writes to the same register: the last edge wins. The bypass always shows the currently presented write.
- No handshake and no stall: one writeback slot is consumed every cycle.

## Test plan
- Reset: hold reset=0 → all rsN_data=0, retire_cnt=0, last_pc=32'hFFFFFFFF, retire_pulse=0. Assert reset asynchronously between edges with R3 written → R3 reads 0 immediately.
- Write/read: write R3=32'h00001234 (wb_pc=32'h10), then with wb_reg_write=0 read rs1_addr=3 → 32'h00001234; retire_cnt=1, last_pc=32'h10, retire_pulse=1 for one cycle.
- Bypass: R5 holds 32'hAAAA0000. Present wb_reg_write=1, wb_dest=5, wb_data=32'h0BADF00D with rs1_addr=rs2_addr=5 → both ports return 32'h0BADF00D in the same cycle, and the array holds it after the edge.
- R0: write R0=32'hFFFFFFFF → rs1_addr=0 reads 0 both in the same cycle and after the edge; the write still counts as retired if wb_pc is valid.
- Bubbles: alternate wb_pc=32'h20 / 32'hFFFFFFFF for 6 cycles → retire_cnt=3, last_pc=32'h20, retire_pulse toggles 1/0.
- Wrap: CNT_W=4, 17 consecutive retiring slots → retire_cnt=1. Assert reset on the cycle of a write to R7 → R7=0 and retire_cnt=0 afterwards.
